// File: rtl/imm_extender_pkg.sv
// Shared decode definitions for the RV32I immediate generator: format
// select codes, fixed widths and the per-format bit-assembly helpers.
package imm_extender_pkg;

  localparam int IMM_W = 32;
  localparam int IR_W  = 25;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_t;

  // IR[k] carries instr[k+7]; every helper indexes IR with that offset applied.
  function automatic logic [IMM_W-1:0] build_i(input logic [IR_W-1:0] ir);
    build_i = {{20{ir[24]}}, ir[24:13]};
  endfunction

  function automatic logic [IMM_W-1:0] build_s(input logic [IR_W-1:0] ir);
    build_s = {{20{ir[24]}}, ir[24:18], ir[4:0]};
  endfunction

  function automatic logic [IMM_W-1:0] build_b(input logic [IR_W-1:0] ir);
    build_b = {{19{ir[24]}}, ir[24], ir[0], ir[23:18], ir[4:1], 1'b0};
  endfunction

  function automatic logic [IMM_W-1:0] build_u(input logic [IR_W-1:0] ir);
    build_u = {ir[24:5], 12'h000};
  endfunction

  function automatic logic [IMM_W-1:0] build_j(input logic [IR_W-1:0] ir);
    build_j = {{11{ir[24]}}, ir[24], ir[12:5], ir[13], ir[23:14], 1'b0};
  endfunction

endpackage

// File: rtl/imm_extender_format_mux.sv
// Pure combinational five-way immediate format builder; unused select
// codes fall back to the I-type layout.
module imm_extender_format_mux
  import imm_extender_pkg::*;
(
  input  logic [2:0]       i_sel,
  input  logic [IR_W-1:0]  i_ir,
  output logic [IMM_W-1:0] o_imm
);

  always_comb begin
    o_imm = build_i(i_ir);
    case (i_sel)
      IMM_I:   o_imm = build_i(i_ir);
      IMM_S:   o_imm = build_s(i_ir);
      IMM_B:   o_imm = build_b(i_ir);
      IMM_U:   o_imm = build_u(i_ir);
      IMM_J:   o_imm = build_j(i_ir);
      default: o_imm = build_i(i_ir);
    endcase
  end

endmodule

// File: rtl/imm_extender.sv
// RV32I decode-stage immediate generator: combinational immediate plus a
// copy registered into the decode->execute pipeline stage.
module imm_extender
  import imm_extender_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       IMM_SEL,
  input  logic [IR_W-1:0]  IR,
  output logic [IMM_W-1:0] IMM,
  output logic [IMM_W-1:0] IMM_R
);

  logic [IMM_W-1:0] w_imm;
  logic [IMM_W-1:0] r_imm;

  imm_extender_format_mux u_mux (
    .i_sel (IMM_SEL),
    .i_ir  (IR),
    .o_imm (w_imm)
  );

  // No enable: the pipeline copy follows the decoder every cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_imm <= 32'h0000_0000;
    end else begin
      r_imm <= w_imm;
    end
  end

  assign IMM   = w_imm;
  assign IMM_R = r_imm;

endmodule

// File: tb/tb_imm_extender.sv
// Directed self-checking bench for imm_extender with hand-computed vectors.
module tb_imm_extender;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  IMM_SEL;
  logic [24:0] IR;
  logic [31:0] IMM;
  logic [31:0] IMM_R;
  logic [31:0] word;

  int n_vec  = 0;
  int n_fail = 0;

  imm_extender dut (
    .CLK     (CLK),
    .RST     (RST),
    .IMM_SEL (IMM_SEL),
    .IR      (IR),
    .IMM     (IMM),
    .IMM_R   (IMM_R)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] w);
    word = w;
    IR   = word[31:7];
  endtask

  initial begin
    RST     = 1'b1;
    IMM_SEL = 3'b000;
    set_word(32'hDEADBEEF);
    #1;
    chk("reset_imm_r", IMM_R, 32'h0000_0000);
    @(negedge CLK);
    RST = 1'b0;

    // 1: format sweep on DEADBEEF
    IMM_SEL = 3'b000; #1; chk("sweep_I",   IMM, 32'hFFFF_FDEA);
    IMM_SEL = 3'b001; #1; chk("sweep_S",   IMM, 32'hFFFF_FDFD);
    IMM_SEL = 3'b010; #1; chk("sweep_B",   IMM, 32'hFFFF_FDFC);
    IMM_SEL = 3'b011; #1; chk("sweep_U",   IMM, 32'hDEAD_B000);
    IMM_SEL = 3'b100; #1; chk("sweep_J",   IMM, 32'hFFFD_B5EA);
    IMM_SEL = 3'b101; #1; chk("sweep_101", IMM, 32'hFFFF_FDEA);

    // 3: remaining undefined codes
    IMM_SEL = 3'b110; #1; chk("undef_110", IMM, 32'hFFFF_FDEA);
    IMM_SEL = 3'b111; #1; chk("undef_111", IMM, 32'hFFFF_FDEA);

    // 2: positive immediates
    set_word(32'h0012_3093);
    IMM_SEL = 3'b000; #1; chk("pos_I",     IMM, 32'h0000_0001);
    IMM_SEL = 3'b011; #1; chk("pos_U",     IMM, 32'h0012_3000);
    set_word(32'h7FF0_0093);
    IMM_SEL = 3'b000; #1; chk("pos_I_max", IMM, 32'h0000_07FF);

    // 4: registered path
    @(negedge CLK);
    set_word(32'hDEADBEEF);
    IMM_SEL = 3'b000;
    @(posedge CLK); #1;
    chk("reg_I", IMM_R, 32'hFFFF_FDEA);
    @(negedge CLK);
    IMM_SEL = 3'b011; #1;
    chk("reg_U_comb",  IMM,   32'hDEAD_B000);
    chk("reg_U_hold",  IMM_R, 32'hFFFF_FDEA);
    @(posedge CLK); #1;
    chk("reg_U", IMM_R, 32'hDEAD_B000);

    // 5: asynchronous reset mid-cycle
    #1;
    RST = 1'b1; #1;
    chk("arst_clear", IMM_R, 32'h0000_0000);
    IMM_SEL = 3'b000; #1;
    chk("arst_comb", IMM, 32'hFFFF_FDEA);
    @(posedge CLK); #1;
    chk("arst_hold", IMM_R, 32'h0000_0000);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("arst_release", IMM_R, 32'hFFFF_FDEA);

    // 6: all-ones and all-zeros
    set_word(32'hFFFF_FFFF);
    IMM_SEL = 3'b010; #1; chk("ones_B", IMM, 32'hFFFF_FFFE);
    IMM_SEL = 3'b100; #1; chk("ones_J", IMM, 32'hFFFF_FFFE);
    IMM_SEL = 3'b001; #1; chk("ones_S", IMM, 32'hFFFF_FFFF);
    IMM_SEL = 3'b000; #1; chk("ones_I", IMM, 32'hFFFF_FFFF);
    IMM_SEL = 3'b011; #1; chk("ones_U", IMM, 32'hFFFF_F000);
    set_word(32'h0000_0000);
    for (int s = 0; s < 8; s++) begin
      IMM_SEL = s[2:0]; #1;
      chk("zeros", IMM, 32'h0000_0000);
    end
    @(posedge CLK); #1;
    chk("zeros_reg", IMM_R, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
